frame_scheduler: RTL
====================

Name: frame_scheduler

Overview:
Top-level frame sequencer for the face detection pipeline. Each frame it runs camera capture, then the integral-image build, then the detection engine. It also acknowledges the engine's per-detection result handshakes and keeps the best detection of each frame. A watchdog timer recovers the pipeline when the engine hangs.

Parameters:
WIDTH_POSI, 8, width of xpos/ypos/length.
TIMEOUT_W, 24, width of the watchdog counter.
TIMEOUT_CYCLES, 24'd5_000_000, maximum number of cycles allowed in DETECT.
RECOVER_CYCLES, 3'd4, number of cycles eng_rst is held high.

Ports:
clk  in  1  system clock; every register updates on its rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  level; while high, frames run back to back.
cam_capture_start  out  1  one-cycle pulse; starts capture of the next frame.
cam_frame_done  in  1  one-cycle pulse; frame is in the buffer.
integ_start  out  1  one-cycle pulse; starts the integral-image build.
integ_done  in  1  one-cycle pulse; integral image is complete.
new_image_ready  out  1  level to the engine; integral image is valid.
write_next_frame  in  1  pulse from the engine; engine has finished the frame.
det_start  in  1  pulse from the engine; a detection is presented on xpos/ypos/length.
xpos  in  WIDTH_POSI  detection x position.
ypos  in  WIDTH_POSI  detection y position.
length  in  WIDTH_POSI  detection window side length.
det_done  out  1  one-cycle acknowledge of det_start.
eng_rst  out  1  active-high reset to the engine; asserted during recovery.
res_valid  out  1  last published frame had at least one detection.
res_x  out  WIDTH_POSI  best detection x position.
res_y  out  WIDTH_POSI  best detection y position.
res_len  out  WIDTH_POSI  best detection length.
res_count  out  4  number of detections in the last published frame, saturating.
frame_count  out  16  number of completed frames, wrapping.
timeout_flag  out  1  sticky watchdog-fired status.
state  out  3  current FSM state encoding.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE and every output is 0, including res_* , counters and timeout_flag. Reset mid-frame abandons the frame immediately; the next cycle is IDLE with all outputs 0.
- All outputs are registered.
- State encodings: IDLE=0, CAPTURE=1, INTEG=2, DETECT=3, PUBLISH=4, RECOVER=5. Encodings 6 and 7 go to IDLE on the next cycle.
- IDLE: if enable=1, go to CAPTURE; cam_capture_start is high for the one cycle in which state shows CAPTURE.
- CAPTURE: wait for cam_frame_done. On it, go to INTEG; integ_start pulses in the first INTEG cycle.
- INTEG: wait for integ_done. On it:
  - go to DETECT;
  - new_image_ready goes to 1;
  - per-frame count and best register clear;
  - watchdog counter loads 0.
- DETECT:
  - new_image_ready stays 1.
  - Watchdog increments once per cycle.
  - det_start sampled high → det_done is high on the next cycle. Back-to-back det_start produces back-to-back det_done.
  - Each det_start increments the per-frame count, saturating at 15.
  - The best register takes {xpos, ypos, length} when the frame count was 0, or when length > stored length (strictly greater). Ties keep the earlier detection.
  - write_next_frame sampled high → go to PUBLISH; new_image_ready drops to 0 in that same transition.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no write_next_frame → go to RECOVER.
  - write_next_frame and watchdog expiry in the same cycle: write_next_frame wins.
  - det_start in the same cycle as write_next_frame: counted and acknowledged. det_done still pulses during the first PUBLISH cycle.
- PUBLISH (one cycle):
  - res_x/res_y/res_len and res_count load from the per-frame registers;
  - res_valid = (count != 0);
  - frame_count increments, wrapping 16'hFFFF→0;
  - then go to CAPTURE if enable=1 (cam_capture_start pulses), else IDLE.
- RECOVER:
  - new_image_ready=0;
  - eng_rst=1 for exactly RECOVER_CYCLES cycles;
  - timeout_flag is set and stays 1 until rst;
  - res_* and frame_count are not updated;
  - then go to IDLE.
- det_start outside DETECT is ignored: no count, no det_done.
- cam_frame_done and integ_done outside their own wait state are ignored.
- enable dropping mid-frame: the current frame runs to PUBLISH, then the FSM goes to IDLE. enable is only sampled in IDLE and PUBLISH.
- Output pulses last exactly one cycle. Level outputs are glitch-free because they are registered.

Test Plan:
1. Nominal frame: enable=1, cam_frame_done 10 cycles after cam_capture_start, integ_done 20 cycles later, write_next_frame 50 cycles later, no detections → state sequence 1,2,3,4,1; frame_count=1; res_valid=0; res_count=0.
2. Detections: during DETECT, det_start with lengths 24, 40, 40, 32 (x=10,20,30,40) → four det_done pulses, each one cycle after its det_start; after PUBLISH res_count=4, res_x=20, res_len=40, res_valid=1.
3. Saturation and overlap: 20 back-to-back det_start pulses, the last in the same cycle as write_next_frame → 20 det_done pulses; res_count=15; frame_count increments.
4. Watchdog: TIMEOUT_CYCLES=100 and no write_next_frame → RECOVER entered after 100 DETECT cycles; eng_rst high for 4 cycles; timeout_flag=1; frame_count and res_* unchanged; state returns to IDLE. write_next_frame asserted in the expiry cycle → PUBLISH instead.
5. Reset and enable: assert rst for one cycle in the middle of DETECT → next cycle state=0 and all outputs 0. Separately, drop enable during INTEG → frame completes and FSM goes to IDLE with no further cam_capture_start.
6. Spurious inputs: pulse det_start, integ_done and write_next_frame while in CAPTURE → no det_done, state stays 1, counters unchanged.

Source files
------------

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: capture -> integral image -> detection -> publish, with an
// engine watchdog that pulses eng_rst and falls back to IDLE when DETECT stalls.
module frame_scheduler #(
    parameter int unsigned         WIDTH_POSI     = 8,
    parameter int unsigned         TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd5_000_000,
    parameter logic [2:0]          RECOVER_CYCLES = 3'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  cam_capture_start,
    input  logic                  cam_frame_done,
    output logic                  integ_start,
    input  logic                  integ_done,
    output logic                  new_image_ready,
    input  logic                  write_next_frame,
    input  logic                  det_start,
    input  logic [WIDTH_POSI-1:0] xpos,
    input  logic [WIDTH_POSI-1:0] ypos,
    input  logic [WIDTH_POSI-1:0] length,
    output logic                  det_done,
    output logic                  eng_rst,
    output logic                  res_valid,
    output logic [WIDTH_POSI-1:0] res_x,
    output logic [WIDTH_POSI-1:0] res_y,
    output logic [WIDTH_POSI-1:0] res_len,
    output logic [3:0]            res_count,
    output logic [15:0]           frame_count,
    output logic                  timeout_flag,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCapture = 3'd1,
        StInteg   = 3'd2,
        StDetect  = 3'd3,
        StPublish = 3'd4,
        StRecover = 3'd5
    } state_e;

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST    = TIMEOUT_CYCLES - 1'b1;
    localparam logic [2:0]           RECOVER_LAST = RECOVER_CYCLES - 3'd1;

    state_e                r_state;
    logic                  r_cam_start;
    logic                  r_integ_start;
    logic                  r_nir;
    logic                  r_det_done;
    logic                  r_eng_rst;
    logic                  r_timeout;
    logic [TIMEOUT_W-1:0]  r_wdog;
    logic [2:0]            r_rec_cnt;
    logic [3:0]            r_cnt;
    logic [WIDTH_POSI-1:0] r_best_x;
    logic [WIDTH_POSI-1:0] r_best_y;
    logic [WIDTH_POSI-1:0] r_best_len;
    logic                  r_res_valid;
    logic [WIDTH_POSI-1:0] r_res_x;
    logic [WIDTH_POSI-1:0] r_res_y;
    logic [WIDTH_POSI-1:0] r_res_len;
    logic [3:0]            r_res_count;
    logic [15:0]           r_frame_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_cam_start   <= 1'b0;
            r_integ_start <= 1'b0;
            r_nir         <= 1'b0;
            r_det_done    <= 1'b0;
            r_eng_rst     <= 1'b0;
            r_timeout     <= 1'b0;
            r_wdog        <= '0;
            r_rec_cnt     <= '0;
            r_cnt         <= '0;
            r_best_x      <= '0;
            r_best_y      <= '0;
            r_best_len    <= '0;
            r_res_valid   <= 1'b0;
            r_res_x       <= '0;
            r_res_y       <= '0;
            r_res_len     <= '0;
            r_res_count   <= '0;
            r_frame_count <= '0;
        end else begin
            r_cam_start   <= 1'b0;
            r_integ_start <= 1'b0;
            r_det_done    <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (enable) begin
                        r_state     <= StCapture;
                        r_cam_start <= 1'b1;
                    end
                end
                StCapture: begin
                    if (cam_frame_done) begin
                        r_state       <= StInteg;
                        r_integ_start <= 1'b1;
                    end
                end
                StInteg: begin
                    if (integ_done) begin
                        r_state    <= StDetect;
                        r_nir      <= 1'b1;
                        r_cnt      <= '0;
                        r_best_x   <= '0;
                        r_best_y   <= '0;
                        r_best_len <= '0;
                        r_wdog     <= '0;
                    end
                end
                StDetect: begin
                    if (det_start) begin
                        r_det_done <= 1'b1;
                        // Strictly-greater keeps the earliest of equal-length detections.
                        if (r_cnt == 4'd0 || length > r_best_len) begin
                            r_best_x   <= xpos;
                            r_best_y   <= ypos;
                            r_best_len <= length;
                        end
                        if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
                    end
                    if (write_next_frame) begin
                        r_state <= StPublish;
                        r_nir   <= 1'b0;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_state   <= StRecover;
                        r_nir     <= 1'b0;
                        r_eng_rst <= 1'b1;
                        r_timeout <= 1'b1;
                        r_rec_cnt <= '0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                StPublish: begin
                    r_res_x       <= r_best_x;
                    r_res_y       <= r_best_y;
                    r_res_len     <= r_best_len;
                    r_res_count   <= r_cnt;
                    r_res_valid   <= (r_cnt != 4'd0);
                    r_frame_count <= r_frame_count + 16'd1;
                    if (enable) begin
                        r_state     <= StCapture;
                        r_cam_start <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRecover: begin
                    if (r_rec_cnt == RECOVER_LAST) begin
                        r_eng_rst <= 1'b0;
                        r_state   <= StIdle;
                    end else begin
                        r_rec_cnt <= r_rec_cnt + 3'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign state             = r_state;
    assign cam_capture_start = r_cam_start;
    assign integ_start       = r_integ_start;
    assign new_image_ready   = r_nir;
    assign det_done          = r_det_done;
    assign eng_rst           = r_eng_rst;
    assign timeout_flag      = r_timeout;
    assign res_valid         = r_res_valid;
    assign res_x             = r_res_x;
    assign res_y             = r_res_y;
    assign res_len           = r_res_len;
    assign res_count         = r_res_count;
    assign frame_count       = r_frame_count;

endmodule
